// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access
//
// Pipeline memory stage placed directly after the execute stage. It runs the
// data-memory request/ready handshake for loads and stores, lines store data
// up with the addressed byte lanes, extends load data and registers the
// result for writeback. While an access waits on memory, mem_stall is raised
// so that the upstream stages hold their outputs.
//
// Ports
//   clk, rst        pipeline clock, synchronous active-high reset
//   alu_result      execute result, also the effective load/store address
//   rs2E            store data
//   write_regE      instruction writes a register
//   info_loadE      load type (0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU)
//   info_storeE     store type (0 none, 1 SB, 2 SH, 3 SW)
//   dstreg_addrE    destination register
//   dmem_*          data-memory request/response handshake
//   mem_stall       combinational hold request to the upstream stages
//   misalign_err    registered one-cycle pulse on a misaligned access
//   wb_data, write_regM, dstreg_addrM   registered outputs to writeback
// ---------------------------------------------------------------------------
module memory_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2E,
  input  logic        write_regE,
  input  logic [2:0]  info_loadE,
  input  logic [1:0]  info_storeE,
  input  logic [4:0]  dstreg_addrE,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic [31:0] wb_data,
  output logic        write_regM,
  output logic [4:0]  dstreg_addrM
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_next;

  logic        is_store;
  logic        is_load;
  logic        aligned;
  logic        access_ok;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode the access. A store takes priority, so a load code is ignored
  // whenever a store is also present. Codes 6 and 7 are not loads. Byte
  // accesses are always aligned; halves need bit 0 clear, words need both
  // low bits clear. A misaligned access never reaches memory.
  always_comb begin
    is_store = (info_storeE != 2'd0);
    is_load  = !is_store && (info_loadE >= 3'd1) && (info_loadE <= 3'd5);
    aligned  = 1'b1;
    if (is_store) begin
      case (info_storeE)
        2'd2:    aligned = !alu_result[0];
        2'd3:    aligned = (alu_result[1:0] == 2'b00);
        default: aligned = 1'b1;
      endcase
    end else if (is_load) begin
      case (info_loadE)
        3'd2, 3'd5: aligned = !alu_result[0];
        3'd3:       aligned = (alu_result[1:0] == 2'b00);
        default:    aligned = 1'b1;
      endcase
    end
    access_ok  = (is_store || is_load) && aligned;
    misaligned = (is_store || is_load) && !aligned;
  end

  // Memory request and store lane alignment. The upstream stages hold their
  // outputs while stalled, so the request stays identical across wait
  // states without any local capture. Reset suppresses request and stall.
  always_comb begin
    dmem_req   = access_ok && !rst;
    mem_stall  = access_ok && !dmem_ready && !rst;
    dmem_we    = is_store;
    dmem_addr  = {alu_result[31:2], 2'b00};
    dmem_be    = 4'b1111;
    dmem_wdata = rs2E;
    case (info_storeE)
      2'd1: begin
        dmem_be    = 4'b0001 << alu_result[1:0];
        dmem_wdata = {4{rs2E[7:0]}};
      end
      2'd2: begin
        dmem_be    = 4'b0011 << alu_result[1:0];
        dmem_wdata = {2{rs2E[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = rs2E;
      end
    endcase
  end

  // Pick the addressed byte or half out of the read word and extend it.
  always_comb begin
    ld_byte = dmem_rdata[{alu_result[1:0], 3'b000} +: 8];
    ld_half = dmem_rdata[{alu_result[1], 4'b0000} +: 16];
    case (info_loadE)
      3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IDLE moves to WAIT when an access is not accepted in its first cycle;
  // WAIT returns to IDLE on the cycle memory answers. A WAIT with no access
  // presented cannot normally happen, but falls back to IDLE to be safe.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (access_ok && !dmem_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!access_ok || dmem_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Writeback register. A stall inserts a bubble while holding data and
  // destination. A completing load registers the extended data. Everything
  // else passes the ALU result through, with stores and misaligned accesses
  // never writing a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data      <= 32'd0;
      write_regM   <= 1'b0;
      dstreg_addrM <= 5'd0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misaligned;
      if (mem_stall) begin
        write_regM <= 1'b0;
      end else if (access_ok && is_load) begin
        wb_data      <= ld_data;
        write_regM   <= write_regE;
        dstreg_addrM <= dstreg_addrE;
      end else begin
        wb_data      <= alu_result;
        write_regM   <= write_regE && !is_store && !misaligned;
        dstreg_addrM <= dstreg_addrE;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// ---------------------------------------------------------------------------
// tb_memory_access
//
// Self-checking bench for memory_access. Each transaction driven by
// applyStimulus pushes its expected writeback onto a scoreboard queue; the
// entry is popped and compared once the DUT registers its result. Memory is
// modelled by the bench, answering after a chosen number of wait states.
// ---------------------------------------------------------------------------
module tb_memory_access;

  logic        clk;
  logic        rst;
  logic [31:0] alu_result;
  logic [31:0] rs2E;
  logic        write_regE;
  logic [2:0]  info_loadE;
  logic [1:0]  info_storeE;
  logic [4:0]  dstreg_addrE;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall;
  logic        misalign_err;
  logic [31:0] wb_data;
  logic        write_regM;
  logic [4:0]  dstreg_addrM;

  typedef struct packed {
    logic [31:0] wb;
    logic        wr;
    logic [4:0]  dst;
    logic        mis;
  } exp_t;

  exp_t scoreboard[$];

  int checks = 0;
  int errors = 0;

  memory_access dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result   (alu_result),
    .rs2E         (rs2E),
    .write_regE   (write_regE),
    .info_loadE   (info_loadE),
    .info_storeE  (info_storeE),
    .dstreg_addrE (dstreg_addrE),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready),
    .mem_stall    (mem_stall),
    .misalign_err (misalign_err),
    .wb_data      (wb_data),
    .write_regM   (write_regM),
    .dstreg_addrM (dstreg_addrM)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference load extension, written from the shifted read word.
  function automatic logic [31:0] modelLoad(input logic [2:0] ld,
                                            input logic [31:0] addr,
                                            input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (32'(addr[1:0]) * 8);
    case (ld)
      3'd1:    return {{24{sh[7]}}, sh[7:0]};
      3'd2:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  // Drives one transaction starting just after a rising edge and returns
  // just after the edge on which the result is registered. nwait is the
  // number of wait states the memory model inserts before answering.
  task automatic applyStimulus(input string tag, input logic [2:0] ld,
                               input logic [1:0] st, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic wr,
                               input logic [4:0] dst, input logic [31:0] rd,
                               input int nwait);
    logic        store;
    logic        load;
    logic        ok;
    logic [3:0]  be_exp;
    logic [31:0] wd_exp;
    exp_t        e;
    exp_t        got;
    int          req_cycles;
    store = (st != 2'd0);
    load  = !store && (ld >= 3'd1) && (ld <= 3'd5);
    ok = 1'b1;
    if (store && st == 2'd2) ok = !addr[0];
    if (store && st == 2'd3) ok = (addr[1:0] == 2'b00);
    if (load && (ld == 3'd2 || ld == 3'd5)) ok = !addr[0];
    if (load && ld == 3'd3) ok = (addr[1:0] == 2'b00);
    case (st)
      2'd1: begin be_exp = 4'b0001 << addr[1:0]; wd_exp = {4{rs2[7:0]}}; end
      2'd2: begin be_exp = 4'b0011 << addr[1:0]; wd_exp = {2{rs2[15:0]}}; end
      default: begin be_exp = 4'b1111; wd_exp = rs2; end
    endcase

    e.dst = dst;
    e.mis = (store || load) && !ok;
    if (load && ok) begin
      e.wb = modelLoad(ld, addr, rd);
      e.wr = wr;
    end else begin
      e.wb = addr;
      e.wr = wr && !store && ok;
    end
    scoreboard.push_back(e);

    alu_result   = addr;
    rs2E         = rs2;
    write_regE   = wr;
    info_loadE   = ld;
    info_storeE  = st;
    dstreg_addrE = dst;
    dmem_rdata   = rd;
    req_cycles   = 0;

    if ((store || load) && ok) begin
      for (int i = 0; i <= nwait; i++) begin
        dmem_ready = (i == nwait);
        #4;
        if (dmem_req) req_cycles++;
        checkOutput({tag, ".stall"}, 32'(mem_stall), 32'(i < nwait));
        if (i == 0) begin
          checkOutput({tag, ".we"}, 32'(dmem_we), 32'(store));
          checkOutput({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
          checkOutput({tag, ".be"}, 32'(dmem_be), 32'(be_exp));
          if (store) checkOutput({tag, ".wdata"}, dmem_wdata, wd_exp);
        end
        @(posedge clk);
        #1;
        if (i < nwait) checkOutput({tag, ".bubble"}, 32'(write_regM), 32'd0);
      end
      checkOutput({tag, ".reqcycles"}, 32'(req_cycles), 32'(nwait + 1));
    end else begin
      dmem_ready = 1'b1;
      #4;
      checkOutput({tag, ".noreq"}, 32'(dmem_req), 32'd0);
      checkOutput({tag, ".nostall"}, 32'(mem_stall), 32'd0);
      @(posedge clk);
      #1;
    end

    if (scoreboard.size() == 0) begin
      checkOutput({tag, ".sbempty"}, 32'd0, 32'd1);
    end else begin
      got.wb  = wb_data;
      got.wr  = write_regM;
      got.dst = dstreg_addrM;
      got.mis = misalign_err;
      e = scoreboard.pop_front();
      checkOutput({tag, ".wb_data"}, got.wb, e.wb);
      checkOutput({tag, ".write_regM"}, 32'(got.wr), 32'(e.wr));
      checkOutput({tag, ".dstreg"}, 32'(got.dst), 32'(e.dst));
      checkOutput({tag, ".misalign"}, 32'(got.mis), 32'(e.mis));
    end
  endtask

  // Main sequence: reset, directed cases, randomised loads, reset in WAIT.
  initial begin
    logic [31:0] ra;
    logic [31:0] rdv;
    logic [2:0]  lt;
    rst = 1'b1;
    alu_result = 32'd0;
    rs2E = 32'd0;
    write_regE = 1'b1;
    info_loadE = 3'd3;
    info_storeE = 2'd0;
    dstreg_addrE = 5'd7;
    dmem_rdata = 32'd0;
    dmem_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.req", 32'(dmem_req), 32'd0);
    checkOutput("rst.stall", 32'(mem_stall), 32'd0);
    checkOutput("rst.wb_data", wb_data, 32'd0);
    checkOutput("rst.write_regM", 32'(write_regM), 32'd0);
    checkOutput("rst.dstreg", 32'(dstreg_addrM), 32'd0);
    checkOutput("rst.misalign", 32'(misalign_err), 32'd0);
    rst = 1'b0;

    applyStimulus("lw0",   3'd3, 2'd0, 32'h100, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 0);
    applyStimulus("lb",    3'd1, 2'd0, 32'h103, 32'h0, 1'b1, 5'd6, 32'h80FF0000, 0);
    applyStimulus("lbu",   3'd4, 2'd0, 32'h103, 32'h0, 1'b1, 5'd7, 32'h80FF0000, 0);
    applyStimulus("lhu",   3'd5, 2'd0, 32'h102, 32'h0, 1'b1, 5'd8, 32'h80FF0000, 0);
    applyStimulus("lh",    3'd2, 2'd0, 32'h102, 32'h0, 1'b1, 5'd9, 32'h80FF0000, 1);
    applyStimulus("sh",    3'd0, 2'd2, 32'h22, 32'h1234ABCD, 1'b1, 5'd10, 32'h0, 0);
    applyStimulus("sb",    3'd0, 2'd1, 32'h11, 32'h000000EF, 1'b1, 5'd11, 32'h0, 1);
    applyStimulus("sw",    3'd0, 2'd3, 32'h40, 32'hCAFEF00D, 1'b1, 5'd12, 32'h0, 0);
    applyStimulus("lw2",   3'd3, 2'd0, 32'h200, 32'h0, 1'b1, 5'd13, 32'h13579BDF, 2);
    applyStimulus("mislw", 3'd3, 2'd0, 32'h102, 32'h0, 1'b1, 5'd14, 32'h0, 0);
    applyStimulus("alu",   3'd0, 2'd0, 32'h55AA, 32'h0, 1'b1, 5'd15, 32'h0, 0);
    applyStimulus("missh", 3'd0, 2'd2, 32'h23, 32'h0, 1'b1, 5'd16, 32'h0, 0);
    applyStimulus("code6", 3'd6, 2'd0, 32'h77, 32'h0, 1'b1, 5'd17, 32'h0, 0);
    applyStimulus("both",  3'd3, 2'd3, 32'h80, 32'h01020304, 1'b1, 5'd18, 32'h0, 0);

    for (int n = 0; n < 20; n++) begin
      ra  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00} | 32'($urandom_range(0, 3));
      rdv = $urandom;
      case ($urandom_range(0, 4))
        0: lt = 3'd1;
        1: lt = 3'd2;
        2: lt = 3'd3;
        3: lt = 3'd4;
        default: lt = 3'd5;
      endcase
      if (lt == 3'd2 || lt == 3'd5) ra[0] = 1'b0;
      if (lt == 3'd3) ra[1:0] = 2'b00;
      applyStimulus("rnd", lt, 2'd0, ra, 32'h0, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), rdv, int'($urandom_range(0, 3)));
    end

    // Reset while waiting: the request must drop and the outputs clear.
    alu_result = 32'h300;
    info_loadE = 3'd3;
    info_storeE = 2'd0;
    write_regE = 1'b1;
    dstreg_addrE = 5'd21;
    dmem_ready = 1'b0;
    #4;
    checkOutput("rstw.req0", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #4;
    checkOutput("rstw.reqdrop", 32'(dmem_req), 32'd0);
    checkOutput("rstw.stalldrop", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    info_loadE = 3'd0;
    write_regE = 1'b0;
    #3;
    checkOutput("rstw.req", 32'(dmem_req), 32'd0);
    checkOutput("rstw.stall", 32'(mem_stall), 32'd0);
    checkOutput("rstw.wb_data", wb_data, 32'd0);
    checkOutput("rstw.write_regM", 32'(write_regM), 32'd0);
    checkOutput("rstw.dstreg", 32'(dstreg_addrM), 32'd0);
    checkOutput("rstw.misalign", 32'(misalign_err), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus("postrst", 3'd3, 2'd0, 32'h304, 32'h0, 1'b1, 5'd22, 32'h89ABCDEF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
